id_ex_stage: RTL

Pipeline register and operand-forwarding stage directly upstream of the RV32 ALU in the pipelined core. Captures decoded instruction fields from the decode stage each cycle and drives the ALU's `A`, `B` and `ALUControl` inputs. Resolves read-after-write hazards by forwarding results from the MEM and WB stages. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding in front of the ALU.
// Supports stall (hold, with forwarded sources refreshed) and flush (bubble).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            ValidD,
  input  logic [RIDX-1:0] Rs1D,
  input  logic [RIDX-1:0] Rs2D,
  input  logic [RIDX-1:0] RdD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [2:0]      ALUControlD,
  input  logic            ALUSrcAD,
  input  logic            ALUSrcBD,
  input  logic            RegWriteD,
  input  logic [RIDX-1:0] RdM,
  input  logic            RegWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [RIDX-1:0] RdW,
  input  logic            RegWriteW,
  input  logic [XLEN-1:0] ResultW,
  output logic            ValidE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] WriteDataE,
  output logic [RIDX-1:0] RdE,
  output logic            RegWriteE,
  output logic [RIDX-1:0] Rs1E,
  output logic [RIDX-1:0] Rs2E,
  output logic            IllegalE
);

  logic            valid_r;
  logic [RIDX-1:0] rs1_r;
  logic [RIDX-1:0] rs2_r;
  logic [RIDX-1:0] rd_r;
  logic [XLEN-1:0] rd1_r;
  logic [XLEN-1:0] rd2_r;
  logic [XLEN-1:0] imm_r;
  logic [XLEN-1:0] pc_r;
  logic [2:0]      alu_ctrl_r;
  logic            src_a_sel_r;
  logic            src_b_sel_r;
  logic            reg_write_r;

  logic [XLEN-1:0] fwd_a_s;
  logic [XLEN-1:0] fwd_b_s;

  // ALU codes with no assigned operation
  function automatic logic is_illegal_op(input logic [2:0] op);
    logic res;
    case (op)
      3'b100:  res = 1'b1;
      3'b110:  res = 1'b1;
      3'b111:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Pipeline register: flush beats stall; a stall refreshes rd1/rd2 with the forwarded values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      rs1_r       <= {RIDX{1'b0}};
      rs2_r       <= {RIDX{1'b0}};
      rd_r        <= {RIDX{1'b0}};
      rd1_r       <= {XLEN{1'b0}};
      rd2_r       <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      pc_r        <= {XLEN{1'b0}};
      alu_ctrl_r  <= 3'b000;
      src_a_sel_r <= 1'b0;
      src_b_sel_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (Flush) begin
      valid_r     <= 1'b0;
      rs1_r       <= {RIDX{1'b0}};
      rs2_r       <= {RIDX{1'b0}};
      rd_r        <= {RIDX{1'b0}};
      rd1_r       <= {XLEN{1'b0}};
      rd2_r       <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      pc_r        <= {XLEN{1'b0}};
      alu_ctrl_r  <= 3'b000;
      src_a_sel_r <= 1'b0;
      src_b_sel_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (Stall) begin
      rd1_r <= fwd_a_s;
      rd2_r <= fwd_b_s;
    end else begin
      valid_r     <= ValidD;
      rs1_r       <= Rs1D;
      rs2_r       <= Rs2D;
      rd_r        <= RdD;
      rd1_r       <= RD1D;
      rd2_r       <= RD2D;
      imm_r       <= ImmExtD;
      pc_r        <= PCD;
      alu_ctrl_r  <= ALUControlD;
      src_a_sel_r <= ALUSrcAD;
      src_b_sel_r <= ALUSrcBD;
      reg_write_r <= RegWriteD & ValidD;
    end
  end

  // Operand A forwarding: MEM beats WB, x0 never forwarded
  always_comb begin
    fwd_a_s = rd1_r;
    if (RegWriteM && (RdM != {RIDX{1'b0}}) && (RdM == rs1_r)) begin
      fwd_a_s = ALUResultM;
    end else if (RegWriteW && (RdW != {RIDX{1'b0}}) && (RdW == rs1_r)) begin
      fwd_a_s = ResultW;
    end else begin
      fwd_a_s = rd1_r;
    end
  end

  // Operand B forwarding, same rules on rs2
  always_comb begin
    fwd_b_s = rd2_r;
    if (RegWriteM && (RdM != {RIDX{1'b0}}) && (RdM == rs2_r)) begin
      fwd_b_s = ALUResultM;
    end else if (RegWriteW && (RdW != {RIDX{1'b0}}) && (RdW == rs2_r)) begin
      fwd_b_s = ResultW;
    end else begin
      fwd_b_s = rd2_r;
    end
  end

  assign SrcAE       = src_a_sel_r ? pc_r : fwd_a_s;
  assign SrcBE       = src_b_sel_r ? imm_r : fwd_b_s;
  assign WriteDataE  = fwd_b_s;
  assign ValidE      = valid_r;
  assign ALUControlE = alu_ctrl_r;
  assign RdE         = rd_r;
  assign RegWriteE   = reg_write_r;
  assign Rs1E        = rs1_r;
  assign Rs2E        = rs2_r;
  assign IllegalE    = valid_r & is_illegal_op(alu_ctrl_r);

endmodule
